// File: rtl/countdown_timer.sv
// Loadable 4-digit BCD countdown timer (SS.hh). A prescaler divides clk into 1/100 s
// steps; digits borrow upward and a one-cycle done pulse marks arrival at 00.00.
module countdown_timer #(
  parameter int unsigned TICKS_PER_HUNDREDTH = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start,
  input  logic        stop,
  output logic [15:0] digits,
  output logic        running,
  output logic        done
);

  localparam int unsigned DIG_W   = 16;
  localparam int unsigned NIB_N   = 4;
  localparam int unsigned CNT_W   = (TICKS_PER_HUNDREDTH > 1) ? $clog2(TICKS_PER_HUNDREDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICKS_PER_HUNDREDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_presc;
  logic [CNT_W-1:0]   w_presc_nxt;
  logic [DIG_W-1:0]   r_digits;
  logic [DIG_W-1:0]   w_digits_nxt;
  logic [DIG_W-1:0]   w_load_clamped;
  logic [DIG_W-1:0]   w_dec;
  logic               w_tc;
  logic               r_running;
  logic               r_done;
  logic               w_running_nxt;
  logic               w_done_nxt;

  assign digits  = r_digits;
  assign running = r_running;
  assign done    = r_done;
  assign w_tc    = (r_presc == CNT_MAX);

  // Saturate any non-BCD nibble of the load value to 9
  always_comb begin
    w_load_clamped = '0;
    for (int i = 0; i < NIB_N; i++) begin
      w_load_clamped[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
    end
  end

  // One BCD decrement step, borrowing from hundredths upward
  always_comb begin
    logic v_borrow;
    w_dec    = r_digits;
    v_borrow = 1'b1;
    for (int i = 0; i < NIB_N; i++) begin
      if (v_borrow) begin
        if (r_digits[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_digits[4*i +: 4] - 4'd1;
          v_borrow        = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_digits <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_presc  <= w_presc_nxt;
      r_digits <= w_digits_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_presc_nxt  = r_presc;
    w_digits_nxt = r_digits;
    case (r_state)
      S_IDLE, S_PAUSED: begin
        if (load) begin
          w_state_nxt  = S_IDLE;
          w_presc_nxt  = '0;
          w_digits_nxt = w_load_clamped;
        end else if (start && !stop && (r_digits != '0)) begin
          w_state_nxt = S_RUN;
          if (r_state == S_IDLE) w_presc_nxt = '0;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_PAUSED;
        end else if (w_tc) begin
          w_presc_nxt  = '0;
          w_digits_nxt = w_dec;
          if (w_dec == '0) w_state_nxt = S_EXPIRED;
        end else begin
          w_presc_nxt = r_presc + CNT_W'(1);
        end
      end
      S_EXPIRED: begin
        if (load) begin
          w_state_nxt  = S_IDLE;
          w_presc_nxt  = '0;
          w_digits_nxt = w_load_clamped;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered status outputs follow the state transition taken on the same edge
  always_comb begin
    w_running_nxt = (w_state_nxt == S_RUN);
    w_done_nxt    = (r_state == S_RUN) && (w_state_nxt == S_EXPIRED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_running <= w_running_nxt;
      r_done    <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: hand-derived vector table on a 1-tick instance, then
// directed corner sequences and random traffic on a 4-tick instance against a model.
module tb_countdown_timer;

  localparam int unsigned T4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, ld1, st1, sp1, run1, done1;
  logic [15:0] lv1, dig1;
  logic        rst4, ld4, st4, sp4, run4, done4;
  logic [15:0] lv4, dig4;

  countdown_timer #(.TICKS_PER_HUNDREDTH(1)) dut1 (
    .clk(clk), .reset(rst1), .load(ld1), .load_value(lv1), .start(st1), .stop(sp1),
    .digits(dig1), .running(run1), .done(done1));

  countdown_timer #(.TICKS_PER_HUNDREDTH(T4)) dut4 (
    .clk(clk), .reset(rst4), .load(ld4), .load_value(lv4), .start(st4), .stop(sp4),
    .digits(dig4), .running(run4), .done(done4));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // ---------------- table of single-cycle vectors for the TICKS=1 instance
  typedef struct {
    logic        rst, ld;
    logic [15:0] lv;
    logic        st, sp;
    logic [15:0] e_dig;
    logic        e_run, e_done;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic l, input logic [15:0] v, input logic s,
                              input logic p, input logic [15:0] d, input logic ru, input logic dn);
    vec_t x;
    x.rst = r; x.ld = l; x.lv = v; x.st = s; x.sp = p;
    x.e_dig = d; x.e_run = ru; x.e_done = dn;
    return x;
  endfunction

  vec_t tbl[29];

  // ---------------- behavioural model: value held as an integer count of hundredths
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
  int m_val, m_ph, m_mode;
  bit m_done;

  function automatic int decode(input logic [15:0] v);
    int acc = 0;
    for (int i = 3; i >= 0; i--) begin
      int n;
      n = int'(v[4*i +: 4]);
      acc = acc * 10 + ((n > 9) ? 9 : n);
    end
    return acc;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_step(input logic r, input logic l, input logic [15:0] v,
                            input logic s, input logic p);
    m_done = 1'b0;
    if (r) begin
      m_val = 0; m_ph = 0; m_mode = M_IDLE;
    end else if (l && m_mode != M_RUN) begin
      m_val = decode(v); m_ph = 0; m_mode = M_IDLE;
    end else if (m_mode == M_RUN) begin
      if (p) m_mode = M_PAUSE;
      else begin
        m_ph++;
        if (m_ph == int'(T4)) begin
          m_ph = 0;
          m_val--;
          if (m_val == 0) begin m_mode = M_EXP; m_done = 1'b1; end
        end
      end
    end else if ((m_mode == M_IDLE || m_mode == M_PAUSE) && s && !p && m_val != 0) begin
      if (m_mode == M_IDLE) m_ph = 0;
      m_mode = M_RUN;
    end
  endtask

  int cyc4 = 0;

  task automatic tick4(input logic r, input logic l, input logic [15:0] v, input logic s, input logic p);
    rst4 = r; ld4 = l; lv4 = v; st4 = s; sp4 = p;
    model_step(r, l, v, s, p);
    @(posedge clk);
    #1;
    cyc4++;
    chk("digits", cyc4, dig4, to_bcd(m_val));
    chk("running", cyc4, 16'(run4), 16'(m_mode == M_RUN));
    chk("done", cyc4, 16'(done4), 16'(m_done));
  endtask

  task automatic idle4(input int n);
    for (int i = 0; i < n; i++) tick4(0, 0, 16'h0, 0, 0);
  endtask

  initial begin
    rst1 = 1; ld1 = 0; lv1 = '0; st1 = 0; sp1 = 0;
    rst4 = 1; ld4 = 0; lv4 = '0; st4 = 0; sp4 = 0;
    m_val = 0; m_ph = 0; m_mode = M_IDLE; m_done = 0;

    //           rst ld  lv        st sp  digits   run done
    tbl[0]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
    tbl[1]  = mk(0, 1, 16'h0003, 0, 0, 16'h0003, 0, 0);
    tbl[2]  = mk(0, 0, 16'h0000, 1, 0, 16'h0003, 1, 0);
    tbl[3]  = mk(0, 0, 16'h0000, 0, 0, 16'h0002, 1, 0);
    tbl[4]  = mk(0, 0, 16'h0000, 0, 0, 16'h0001, 1, 0);
    tbl[5]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1);
    tbl[6]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
    tbl[7]  = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0);
    tbl[8]  = mk(0, 1, 16'hFA9B, 0, 0, 16'h9999, 0, 0);
    tbl[9]  = mk(0, 0, 16'h0000, 1, 1, 16'h9999, 0, 0);
    tbl[10] = mk(0, 0, 16'h0000, 1, 0, 16'h9999, 1, 0);
    tbl[11] = mk(0, 1, 16'h0001, 0, 0, 16'h9998, 1, 0);
    tbl[12] = mk(0, 0, 16'h0000, 0, 1, 16'h9998, 0, 0);
    tbl[13] = mk(0, 0, 16'h0000, 0, 0, 16'h9998, 0, 0);
    tbl[14] = mk(0, 0, 16'h0000, 1, 0, 16'h9998, 1, 0);
    tbl[15] = mk(0, 0, 16'h0000, 0, 0, 16'h9997, 1, 0);
    tbl[16] = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
    tbl[17] = mk(0, 1, 16'h1000, 0, 0, 16'h1000, 0, 0);
    tbl[18] = mk(0, 0, 16'h0000, 1, 0, 16'h1000, 1, 0);
    tbl[19] = mk(0, 0, 16'h0000, 0, 0, 16'h0999, 1, 0);
    tbl[20] = mk(0, 0, 16'h0000, 0, 0, 16'h0998, 1, 0);
    tbl[21] = mk(0, 1, 16'h0000, 0, 0, 16'h0997, 1, 0);
    tbl[22] = mk(0, 0, 16'h0000, 0, 1, 16'h0997, 0, 0);
    tbl[23] = mk(0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0);
    tbl[24] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0);
    tbl[25] = mk(0, 1, 16'h0002, 0, 0, 16'h0002, 0, 0);
    tbl[26] = mk(0, 0, 16'h0000, 1, 0, 16'h0002, 1, 0);
    tbl[27] = mk(0, 0, 16'h0000, 0, 0, 16'h0001, 1, 0);
    tbl[28] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1);

    @(posedge clk);
    #1;
    for (int i = 0; i < 29; i++) begin
      rst1 = tbl[i].rst; ld1 = tbl[i].ld; lv1 = tbl[i].lv; st1 = tbl[i].st; sp1 = tbl[i].sp;
      @(posedge clk);
      #1;
      chk("t1_digits", i, dig1, tbl[i].e_dig);
      chk("t1_running", i, 16'(run1), 16'(tbl[i].e_run));
      chk("t1_done", i, 16'(done1), 16'(tbl[i].e_done));
    end
    rst1 = 1; ld1 = 0; st1 = 0; sp1 = 0;

    // Expiry at 4-cycle step intervals
    tick4(1, 0, 16'h0, 0, 0);
    tick4(0, 1, 16'h0003, 0, 0);
    tick4(0, 0, 16'h0, 1, 0);
    idle4(4);  chk("exp_step1", 0, dig4, 16'h0002);
    idle4(4);  chk("exp_step2", 0, dig4, 16'h0001);
    idle4(3);  chk("exp_pre", 0, 16'(done4), 16'h0000);
    idle4(1);  chk("exp_done", 0, 16'(done4), 16'h0001);
    chk("exp_digits", 0, dig4, 16'h0000);
    idle4(2);  chk("exp_hold", 0, 16'(run4), 16'h0000);

    // Full borrow chain
    tick4(0, 1, 16'h1000, 0, 0);
    tick4(0, 0, 16'h0, 1, 0);
    idle4(4);  chk("borrow1", 0, dig4, 16'h0999);
    idle4(4);  chk("borrow2", 0, dig4, 16'h0998);

    // Pause preserves prescaler phase
    tick4(0, 0, 16'h0, 0, 1);
    tick4(0, 1, 16'h0050, 0, 0);
    tick4(0, 0, 16'h0, 1, 0);
    idle4(6);
    tick4(0, 0, 16'h0, 0, 1);  chk("pause_frz", 0, dig4, 16'h0049);
    idle4(20); chk("pause_hold", 0, dig4, 16'h0049);
    tick4(0, 0, 16'h0, 1, 0);
    idle4(1);  chk("resume1", 0, dig4, 16'h0049);
    idle4(1);  chk("resume2", 0, dig4, 16'h0048);

    // Reset mid-RUN aborts without done
    tick4(0, 0, 16'h0, 0, 1);
    tick4(0, 1, 16'h0006, 0, 0);
    tick4(0, 0, 16'h0, 1, 0);
    idle4(4);  chk("rst_pre", 0, dig4, 16'h0005);
    tick4(1, 0, 16'h0, 0, 0);
    chk("rst_dig", 0, dig4, 16'h0000);
    chk("rst_done", 0, 16'(done4), 16'h0000);
    chk("rst_run", 0, 16'(run4), 16'h0000);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic r, l, s, p;
      logic [15:0] v;
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 19) == 0);
      s = ($urandom_range(0, 9) == 0);
      p = ($urandom_range(0, 29) == 0);
      v = 16'($urandom);
      if ($urandom_range(0, 3) != 0) v = v & 16'h001F;
      tick4(r, l, v, s, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
